// File: rtl/boot_pkg.sv
// Shared types and constants for the UART program download loader.
// Pure declarations; no timing behaviour.
// No flow control of its own.
package boot_pkg;

  // Parser / sequencer states, in frame order
  typedef enum logic [3:0] {
    IDLE,
    TGT,
    ADDR0,
    ADDR1,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DRAIN,
    DONE
  } boot_state_e;

  localparam logic [7:0] SOF_BYTE = 8'hA5;
  localparam logic [7:0] EOF_BYTE = 8'h5A;

  localparam logic TGT_IMEM = 1'b0;
  localparam logic TGT_DMEM = 1'b1;

  // States where a frame is in flight and the inter-byte timer runs
  function automatic logic in_frame(boot_state_e s);
    return (s == TGT) || (s == ADDR0) || (s == ADDR1) || (s == LEN0) ||
           (s == LEN1) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/uart_boot_loader_if.sv
// Memory write port from the boot loader to the instruction/data memory muxes.
// Combinational wiring only.
// Ready/valid: a write transfers on a clock edge with mem_wr_en & mem_wr_ready.
interface uart_boot_loader_if #(
  parameter int ADDR_W = 14
) ();
  logic              mem_wr_en;
  logic              mem_wr_sel;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;
  logic              mem_wr_ready;

  modport master (
    output mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data,
    input  mem_wr_ready
  );

  modport slave (
    input  mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data,
    output mem_wr_ready
  );
endinterface

// File: rtl/boot_wr_channel.sv
// Single-entry write holding register with handshake, overrun detect and write counter.
// Latency: a completed word appears on the port one cycle after word_vld.
// Backpressure: holds the entry until ready; a new word arriving while blocked is dropped and flagged.
module boot_wr_channel #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              word_vld,
  input  logic              word_sel,
  input  logic [ADDR_W-1:0] word_addr,
  input  logic [31:0]       word_dat,
  uart_boot_loader_if.master mem,
  output logic              busy,
  output logic              err_overrun,
  output logic [15:0]       words_written
);

  logic              pend_q;
  logic              sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              overrun_q;
  logic [15:0]       cnt_q;
  logic              xfer;

  assign xfer = pend_q & mem.mem_wr_ready;

  // Holding register: a new word loads when the slot is free or is being emptied this cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q    <= 1'b0;
      sel_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (word_vld) begin
        if (!pend_q || mem.mem_wr_ready) begin
          pend_q <= 1'b1;
          sel_q  <= word_sel;
          addr_q <= word_addr;
          data_q <= word_dat;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (xfer) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Accepted-write counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign mem.mem_wr_en   = pend_q;
  assign mem.mem_wr_sel  = sel_q;
  assign mem.mem_wr_addr = addr_q;
  assign mem.mem_wr_data = data_q;
  assign busy            = pend_q;
  assign err_overrun     = overrun_q;
  assign words_written   = cnt_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Parses framed UART segments into 32-bit words, writes them to imem/dmem, releases CPU after end marker.
// Latency: each byte is consumed on its rx_valid cycle; a write request follows the 4th byte by one cycle.
// Backpressure: none toward the UART; a blocked write port causes later words to be dropped (err_overrun).
module uart_boot_loader #(
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int TMR_W          = 23
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  uart_boot_loader_if.master mem,
  output logic              load_done,
  output logic              cpu_hold,
  output logic              err_checksum,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic [15:0]       words_written
);
  import boot_pkg::*;

  boot_state_e       state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              err_csum_q, err_csum_d;
  logic              err_tmo_q, err_tmo_d;

  logic              word_vld;
  logic [31:0]       word_dat;
  logic              wr_busy;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sel_q      <= TGT_IMEM;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      tmr_q      <= '0;
      err_csum_q <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      tmr_q      <= tmr_d;
      err_csum_q <= err_csum_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  // Frame parser: next state, field capture, running XOR, word hand-off and inter-byte timeout
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    tmr_d      = tmr_q;
    err_csum_d = err_csum_q;
    err_tmo_d  = err_tmo_q;
    word_vld   = 1'b0;
    word_dat   = {rx_data, word_q[31:8]};

    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SOF_BYTE) begin
            state_d = TGT;
          end else if (rx_data == EOF_BYTE) begin
            state_d = DRAIN;
          end
        end
        TGT: begin
          sel_d   = rx_data[0] ? TGT_DMEM : TGT_IMEM;
          csum_d  = rx_data;
          state_d = ADDR0;
        end
        ADDR0: begin
          addr_d  = ADDR_W'(rx_data);
          csum_d  = csum_q ^ rx_data;
          state_d = ADDR1;
        end
        ADDR1: begin
          addr_d  = ADDR_W'({rx_data, 8'(addr_q)});
          csum_d  = csum_q ^ rx_data;
          state_d = LEN0;
        end
        LEN0: begin
          len_d   = {8'h00, rx_data};
          csum_d  = csum_q ^ rx_data;
          state_d = LEN1;
        end
        LEN1: begin
          len_d   = {rx_data, len_q[7:0]};
          csum_d  = csum_q ^ rx_data;
          idx_d   = '0;
          state_d = ({rx_data, len_q[7:0]} == 16'd0) ? CSUM : DATA;
        end
        DATA: begin
          word_d = word_dat;
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            word_vld = 1'b1;
            addr_d   = addr_q + ADDR_W'(1);
            len_d    = len_q - 16'd1;
            if (len_q == 16'd1) begin
              state_d = CSUM;
            end
          end
        end
        CSUM: begin
          if (rx_data != csum_q) begin
            err_csum_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: ;
      endcase
    end

    // DRAIN completes once the holding register is empty; nothing needs a byte here
    if (state_q == DRAIN && !wr_busy) begin
      state_d = DONE;
    end

    // Inter-byte timer: a byte on the expiry cycle takes priority over the timeout
    if (in_frame(state_q)) begin
      if (rx_valid) begin
        tmr_d = '0;
      end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
        tmr_d     = '0;
        err_tmo_d = 1'b1;
        idx_d     = '0;
        state_d   = IDLE;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end else begin
      tmr_d = '0;
    end
  end

  boot_wr_channel #(
    .ADDR_W(ADDR_W)
  ) u_wr (
    .clk          (clk),
    .reset_n      (reset_n),
    .word_vld     (word_vld),
    .word_sel     (sel_q),
    .word_addr    (addr_q),
    .word_dat     (word_dat),
    .mem          (mem),
    .busy         (wr_busy),
    .err_overrun  (err_overrun),
    .words_written(words_written)
  );

  assign load_done    = (state_q == DONE);
  assign cpu_hold     = (state_q != DONE);
  assign err_checksum = err_csum_q;
  assign err_timeout  = err_tmo_q;

endmodule
